uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive buffer directly downstream of the UART RX FSM and deserializer.
//  Captures each completed frame, i.e. the parallel byte qualified by the one-cycle
//  data_valid pulse, into a synchronous first-word-fall-through FIFO.
//  Presents frames to the host/bus side over a valid/ready handshake.
//  Flags overflow, because the receiver cannot be back-pressured.
// PARAMETERS
//  DATA_WIDTH  8  width of one received frame (deserializer output width)
//  ADDR_WIDTH  3  log2 of FIFO depth; DEPTH = 2**ADDR_WIDTH (default 8 entries)
// PORTS
//  clk            in   1             system clock, all logic on rising edge
//  rst            in   1             synchronous, active-high reset
//  rx_data        in   DATA_WIDTH    parallel frame from deserializer
//  rx_data_valid  in   1             one-cycle pulse from RX FSM OUT state; write strobe
//  rd_ready       in   1             consumer accepts rd_data this cycle
//  rd_valid       out  1             rd_data holds the oldest unread frame
//  rd_data        out  DATA_WIDTH    head-of-FIFO frame
//  fifo_count     out  ADDR_WIDTH+1  number of stored frames, 0..DEPTH
//  full           out  1             fifo_count == DEPTH
//  empty          out  1             fifo_count == 0
//  overflow       out  1             sticky: a frame was dropped while full
//  ovf_clr        in   1             clears overflow
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge):
//    - wr_ptr=0, rd_ptr=0, fifo_count=0.
//    - rd_valid=0, empty=1, full=0, overflow=0, rd_data=0.
//    - Storage array is not reset.
//    - Reset mid-operation discards all stored frames.
//    - rx_data_valid coincident with rst is ignored.
//  - Pointers are ADDR_WIDTH+1 bits:
//    - The low ADDR_WIDTH bits index storage.
//    - The MSB is the wrap bit.
//    - Both pointers wrap naturally from 2*DEPTH-1 to 0.
//    - fifo_count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
//    - full  = pointers differ only in MSB.
//    - empty = pointers equal.
//  - Push = rx_data_valid & (~full | pop).
//    - Writes rx_data at wr_ptr; wr_ptr++.
//  - Pop = rd_valid & rd_ready.
//    - rd_ptr++.
//    - rd_ready while rd_valid=0 has no effect.
//  - Outputs:
//    - rd_valid = ~empty (combinational from registered pointers).
//    - rd_data = mem[rd_ptr] when rd_valid, else 0.
//  - Latency: rx_data_valid at edge N -> rd_valid=1 and rd_data=frame after edge N (cycle N+1).
//    - No same-cycle bypass when empty.
//  - Simultaneous push+pop:
//    - Both happen; count unchanged.
//    - When full, the pop frees the slot, so the write is accepted (no overflow).
//    - When empty, pop is impossible (rd_valid=0); the write is stored.
//  - Write while full without pop:
//    - Frame dropped; storage and pointers unchanged.
//    - overflow=1 from the next cycle.
//  - overflow remains set until ovf_clr=1 or rst.
//    - If ovf_clr and a new drop coincide, set wins (overflow stays 1).
//  - FIFO is transparent to framing: parity/stop-error frames never assert rx_data_valid upstream,
//    so they are never written.
//  - Back-to-back rx_data_valid on consecutive cycles must be accepted (no gap required).
// TESTING
//  T1 reset: rst=1 2 cycles -> rd_valid=0, empty=1, full=0, fifo_count=0, overflow=0, rd_data=0.
//  T2 single frame: pulse rx_data_valid with rx_data=8'hA5, rd_ready=0
//     -> next cycle rd_valid=1, rd_data=8'hA5, fifo_count=1.
//     Then rd_ready=1 one cycle -> empty=1.
//  T3 fill/order: write 8'h01..8'h08 back-to-back -> full=1, fifo_count=8.
//     Drain with rd_ready=1 -> rd_data 01..08 in order, then empty.
//  T4 overflow: when full, write 8'hFF with rd_ready=0 -> overflow=1, fifo_count=8, FF never read.
//     ovf_clr=1 -> overflow=0.
//     ovf_clr coincident with a second drop -> overflow stays 1.
//  T5 full push+pop: when full, rx_data_valid=1 (8'h99) and rd_ready=1 same cycle
//     -> head popped, 99 stored, overflow=0, fifo_count=8.
//  T6 wrap/reset: 20 random push/pop cycles crossing pointer wrap
//     -> scoreboard matches, fifo_count correct.
//     rst asserted with 3 frames stored -> empty next cycle.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive buffer that sits directly behind the UART deserializer. It captures
//   every completed frame, qualified by the one-cycle rx_data_valid strobe, into
//   a synchronous first-word-fall-through FIFO. Frames are presented to the host
//   over a valid/ready handshake. The receiver cannot be back-pressured, so a
//   frame that arrives while the FIFO is full is dropped and a sticky overflow
//   flag is raised.
//
// Parameters
//   DATA_WIDTH  width of one frame
//   ADDR_WIDTH  log2 of FIFO depth (DEPTH = 2**ADDR_WIDTH, must be >= 1)
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   rx_data        in   frame from deserializer
//   rx_data_valid  in   one-cycle write strobe
//   rd_ready       in   consumer accepts rd_data this cycle
//   rd_valid       out  rd_data holds the oldest unread frame
//   rd_data        out  head-of-FIFO frame (0 when empty)
//   fifo_count     out  number of stored frames, 0..DEPTH
//   full           out  fifo_count == DEPTH
//   empty          out  fifo_count == 0
//   overflow       out  sticky: a frame was dropped while full
//   ovf_clr        in   clears overflow (a coincident drop wins)
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_data_valid,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // One extra pointer bit distinguishes full from empty when the index bits match.
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;

  logic pop;
  logic push;
  logic drop;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                      (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign fifo_count = wr_ptr - rd_ptr;
  assign rd_valid   = ~empty;

  assign pop  = rd_valid & rd_ready;
  // A pop in the same cycle frees the head slot, so a write into a full FIFO is
  // still accepted when the consumer is draining.
  assign push = rx_data_valid & (~full | pop);
  assign drop = rx_data_valid & full & ~pop;

  assign rd_data = rd_valid ? mem[rd_ptr[ADDR_WIDTH-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  // Storage carries no reset; a write strobe coincident with rst is ignored.
  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] rx_data = '0;
  logic          rx_data_valid = 1'b0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW:0]   fifo_count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          ovf_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  uart_rx_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .fifo_count   (fifo_count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of stored frames plus the sticky flag.
  logic [DW-1:0] mq[$];
  logic          movf = 1'b0;

  typedef struct {
    string         name;
    logic          r;
    logic          v;
    logic [DW-1:0] d;
    logic          rdy;
    logic          clr;
    logic          ev;
    logic [DW-1:0] ed;
    int            ec;
    logic          ef;
    logic          eo;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string name, input logic r, v, input logic [DW-1:0] d,
                              input logic rdy, clr, ev, input logic [DW-1:0] ed,
                              input int ec, input logic ef, eo);
    vec_t e;
    e.name = name; e.r = r; e.v = v; e.d = d; e.rdy = rdy; e.clr = clr;
    e.ev = ev; e.ed = ed; e.ec = ec; e.ef = ef; e.eo = eo;
    tbl.push_back(e);
  endfunction

  // Apply one cycle of inputs, advance the model, and settle after the edge.
  task automatic step(input logic r, v, input logic [DW-1:0] d, input logic rdy, clr);
    int  sz;
    bit  p;
    rst = r; rx_data_valid = v; rx_data = d; rd_ready = rdy; ovf_clr = clr;
    if (r) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      sz = mq.size();
      p  = (sz > 0) && rdy;
      if (p) void'(mq.pop_front());
      if (v && sz == DEPTH && !p) movf = 1'b1;
      else begin
        if (v) mq.push_back(d);
        if (clr) movf = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name, input logic ev, input logic [DW-1:0] ed,
                         input int ec, input logic ef, eo);
    logic ee;
    ee = (ec == 0);
    checks++;
    if (rd_valid !== ev || rd_data !== ed || fifo_count !== (AW+1)'(ec) ||
        full !== ef || empty !== ee || overflow !== eo) begin
      errors++;
      $display("FAIL %s: got valid=%b data=%h count=%0d full=%b empty=%b ovf=%b, expected valid=%b data=%h count=%0d full=%b empty=%b ovf=%b",
               name, rd_valid, rd_data, fifo_count, full, empty, overflow,
               ev, ed, ec, ef, ee, eo);
    end
  endtask

  task automatic compare_model(input string name);
    logic [DW-1:0] hd;
    hd = (mq.size() > 0) ? mq[0] : '0;
    compare(name, mq.size() > 0, hd, mq.size(), mq.size() == DEPTH, movf);
  endtask

  initial begin
    // Reset
    add("t1_rst0", 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    add("t1_rst1", 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    // Single frame, then pop
    add("t2_wr",   0, 1, 8'hA5, 0, 0, 1, 8'hA5, 1, 0, 0);
    add("t2_pop",  0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
    // Fill 01..08 back-to-back; head stays 01
    for (int i = 1; i <= DEPTH; i++)
      add("t3_fill", 0, 1, 8'(i), 0, 0, 1, 8'h01, i, i == DEPTH, 0);
    // Overflow and clear; coincident clear+drop keeps the flag set
    add("t4_drop",    0, 1, 8'hFF, 0, 0, 1, 8'h01, 8, 1, 1);
    add("t4_clr",     0, 0, 8'h00, 0, 1, 1, 8'h01, 8, 1, 0);
    add("t4_clrdrop", 0, 1, 8'hFE, 0, 1, 1, 8'h01, 8, 1, 1);
    add("t4_clr2",    0, 0, 8'h00, 0, 1, 1, 8'h01, 8, 1, 0);
    // Full push+pop: 01 leaves, 99 enters, no overflow
    add("t5_pushpop", 0, 1, 8'h99, 1, 0, 1, 8'h02, 8, 1, 0);
    // Drain: 03..08 then 99, then empty; FF/FE must never appear
    for (int i = 3; i <= DEPTH; i++)
      add("t3_drain", 0, 0, 8'h00, 1, 0, 1, 8'(i), 10 - i, 0, 0);
    add("t3_drain99", 0, 0, 8'h00, 1, 0, 1, 8'h99, 1, 0, 0);
    add("t3_empty",   0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
    add("rdy_empty",  0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
    add("wr_rdy_empty", 0, 1, 8'h3C, 1, 0, 1, 8'h3C, 1, 0, 0);
    // Reset mid-operation with a coincident write strobe
    add("rst_with_wr", 1, 1, 8'h77, 0, 0, 0, 8'h00, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      compare(tbl[i].name, tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].ef, tbl[i].eo);
    end

    // Randomized traffic alternating fill-biased and drain-biased windows so the
    // pointers wrap many times and full/overflow are reached.
    for (int i = 0; i < 400; i++) begin
      logic v, rdy, clr;
      int   wbias;
      wbias = ((i / 25) % 2 == 0) ? 75 : 30;
      v   = ($urandom_range(0, 99) < wbias);
      rdy = ($urandom_range(0, 99) < (100 - wbias));
      clr = ($urandom_range(0, 99) < 6);
      step(1'b0, v, 8'($urandom), rdy, clr);
      compare_model("rand");
    end

    // Reset with three frames stored
    step(1, 0, 8'h00, 0, 0);
    step(0, 1, 8'hAA, 0, 0);
    step(0, 1, 8'hBB, 0, 0);
    step(0, 1, 8'hCC, 0, 0);
    compare("t6_three", 1, 8'hAA, 3, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    compare("t6_rst_empty", 0, 8'h00, 0, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    compare_model("t6_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
